// File: rtl/zpu_alu_issuer_pkg.sv
// Shared ZPU ALU definitions: opcode encodings, issuer state type and defaults.
package zpu_alu_issuer_pkg;

  localparam int ALU_OP_WIDTH = 5;

  localparam logic [ALU_OP_WIDTH-1:0] ALU_NOP     = 5'd0;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_AND     = 5'd1;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OR      = 5'd2;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_NOT     = 5'd3;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_XOR     = 5'd4;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_PLUS    = 5'd5;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SUB     = 5'd6;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_MULT    = 5'd7;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_DIV     = 5'd8;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_MOD     = 5'd9;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_BARREL  = 5'd10;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_IM      = 5'd11;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_LESS    = 5'd12;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_ULESS   = 5'd13;

  // Must cover the slowest multicycle unit (DIV, about 34 cycles) with margin.
  localparam int ALU_ISS_TIMEOUT = 255;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    EXEC   = 2'd2,
    RESULT = 2'd3
  } alu_iss_state_t;

endpackage

// File: rtl/zpu_cycle_watchdog.sv
// Counts consecutive enabled cycles; expired is high during the TIMEOUT-th one.
module zpu_cycle_watchdog #(
  parameter int TIMEOUT = 255,
  parameter int TW      = $clog2(TIMEOUT + 1)
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [TW-1:0] count_reg;

  assign expired = enable && (count_reg == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable && !expired) begin
      count_reg <= count_reg + TW'(1);
    end
  end

endmodule

// File: rtl/zpu_alu_issuer.sv
// Issues one request at a time to the ZPU ALU over the op/done handshake and
// returns the captured result (or a watchdog abort) on a valid/ready port.
module zpu_alu_issuer
  import zpu_alu_issuer_pkg::*;
#(
  parameter int OP_W    = ALU_OP_WIDTH,
  parameter int TIMEOUT = ALU_ISS_TIMEOUT,
  parameter int TW      = $clog2(TIMEOUT + 1)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [OP_W-1:0] req_op,
  input  logic [31:0]     req_a,
  input  logic [31:0]     req_b,
  input  logic            req_idim,
  output logic [31:0]     alu_a,
  output logic [31:0]     alu_b,
  output logic [OP_W-1:0] alu_op,
  output logic            flag_idim,
  input  logic [31:0]     alu_r,
  input  logic            alu_done,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [31:0]     res_data,
  output logic            res_err,
  output logic            busy
);

  localparam logic [OP_W-1:0] OP_NOP = OP_W'(ALU_NOP);

  alu_iss_state_t  state_reg, state_next;
  logic [31:0]     alu_a_reg, alu_a_next;
  logic [31:0]     alu_b_reg, alu_b_next;
  logic            flag_idim_reg, flag_idim_next;
  logic [OP_W-1:0] op_reg, op_next;
  logic [OP_W-1:0] alu_op_reg, alu_op_next;
  logic [31:0]     res_data_reg, res_data_next;
  logic            res_err_reg, res_err_next;
  logic            accept;
  logic            wd_expired;

  zpu_cycle_watchdog #(
    .TIMEOUT (TIMEOUT),
    .TW      (TW)
  ) u_watchdog (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (state_reg != EXEC),
    .enable  (state_reg == EXEC),
    .expired (wd_expired)
  );

  // RESULT hands req_ready to writeback so consume and accept can share a cycle.
  always_comb begin
    case (state_reg)
      IDLE:    req_ready = 1'b1;
      RESULT:  req_ready = res_ready;
      default: req_ready = 1'b0;
    endcase
  end

  assign accept    = req_valid && req_ready;
  assign alu_a     = alu_a_reg;
  assign alu_b     = alu_b_reg;
  assign alu_op    = alu_op_reg;
  assign flag_idim = flag_idim_reg;
  assign res_data  = res_data_reg;
  assign res_err   = res_err_reg;
  assign res_valid = (state_reg == RESULT);
  assign busy      = (state_reg != IDLE);

  always_comb begin
    state_next     = state_reg;
    alu_a_next     = alu_a_reg;
    alu_b_next     = alu_b_reg;
    flag_idim_next = flag_idim_reg;
    op_next        = op_reg;
    res_data_next  = res_data_reg;
    res_err_next   = res_err_reg;

    case (state_reg)
      IDLE: begin
        if (accept) state_next = SETUP;
      end
      SETUP: begin
        state_next = EXEC;
      end
      EXEC: begin
        if (alu_done) begin
          res_data_next = alu_r;
          res_err_next  = 1'b0;
          state_next    = RESULT;
        end else if (wd_expired) begin
          res_data_next = 32'h0;
          res_err_next  = 1'b1;
          state_next    = RESULT;
        end
      end
      RESULT: begin
        if (res_ready) state_next = req_valid ? SETUP : IDLE;
      end
      default: state_next = IDLE;
    endcase

    if (accept) begin
      alu_a_next     = req_a;
      alu_b_next     = req_b;
      flag_idim_next = req_idim;
      op_next        = req_op;
    end

    // Opcode is only presented while executing; NOP elsewhere lets the ALU
    // preload operands in SETUP and clear its multicycle units after EXEC.
    alu_op_next = (state_next == EXEC) ? op_reg : OP_NOP;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      alu_a_reg     <= 32'h0;
      alu_b_reg     <= 32'h0;
      flag_idim_reg <= 1'b0;
      op_reg        <= OP_NOP;
      alu_op_reg    <= OP_NOP;
      res_data_reg  <= 32'h0;
      res_err_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      alu_a_reg     <= alu_a_next;
      alu_b_reg     <= alu_b_next;
      flag_idim_reg <= flag_idim_next;
      op_reg        <= op_next;
      alu_op_reg    <= alu_op_next;
      res_data_reg  <= res_data_next;
      res_err_reg   <= res_err_next;
    end
  end

endmodule

// File: tb/tb_zpu_alu_issuer.sv
// Directed test of zpu_alu_issuer against a small behavioural ALU model.
module tb_zpu_alu_issuer;
  import zpu_alu_issuer_pkg::*;

  localparam int OP_W = ALU_OP_WIDTH;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            req_valid;
  logic            req_ready;
  logic [OP_W-1:0] req_op;
  logic [31:0]     req_a;
  logic [31:0]     req_b;
  logic            req_idim;
  logic [31:0]     alu_a;
  logic [31:0]     alu_b;
  logic [OP_W-1:0] alu_op;
  logic            flag_idim;
  logic [31:0]     alu_r;
  logic            alu_done;
  logic            res_valid;
  logic            res_ready;
  logic [31:0]     res_data;
  logic            res_err;
  logic            busy;

  int n_checks = 0;
  int n_fail   = 0;

  // ALU model behaviour: 0 = done in first EXEC cycle, 1 = done on EXEC cycle lat, 2 = never done
  int          mode = 0;
  int          lat  = 1;
  int          mcnt = 0;
  logic [31:0] sh_reg = 32'h0;

  always #5 clk = ~clk;

  zpu_alu_issuer #(
    .OP_W    (OP_W),
    .TIMEOUT (50)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_idim  (req_idim),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_op    (alu_op),
    .flag_idim (flag_idim),
    .alu_r     (alu_r),
    .alu_done  (alu_done),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_err   (res_err),
    .busy      (busy)
  );

  // Barrel unit preloads alu_a while the opcode is NOP; cycle counter clears too.
  always @(posedge clk) begin
    if (alu_op == ALU_NOP) begin
      mcnt   <= 0;
      sh_reg <= alu_a;
    end else begin
      mcnt <= mcnt + 1;
    end
  end

  function automatic logic [31:0] alu_calc(input logic [OP_W-1:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [31:0] sh);
    case (op)
      ALU_AND:    return a & b;
      ALU_OR:     return a | b;
      ALU_PLUS:   return a + b;
      ALU_MULT:   return a * b;
      ALU_DIV:    return (b == 0) ? 32'h0 : a / b;
      ALU_BARREL: return $unsigned($signed(sh) >>> b[4:0]);
      default:    return 32'h0;
    endcase
  endfunction

  always_comb begin
    alu_done = 1'b0;
    alu_r    = 32'h0;
    case (mode)
      0: if (alu_op != ALU_NOP) begin
        alu_done = 1'b1;
        alu_r    = alu_calc(alu_op, alu_a, alu_b, sh_reg);
      end
      1: if (alu_op != ALU_NOP && mcnt == lat - 1) begin
        alu_done = 1'b1;
        alu_r    = alu_calc(alu_op, alu_a, alu_b, sh_reg);
      end
      default: alu_r = 32'hDEAD_BEEF;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Returns at the SETUP cycle (negedge + 1) after the request is accepted.
  task automatic send(input logic [OP_W-1:0] op, input logic [31:0] a, input logic [31:0] b);
    int n;
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    req_idim  = 1'b0;
    #1;
    n = 0;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("send_ready", {31'h0, req_ready}, 32'h1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    #1;
  endtask

  task automatic wait_result(input string tag, output int cycles);
    int n;
    n = 0;
    while (!res_valid && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    check({tag, "_res_valid"}, {31'h0, res_valid}, 32'h1);
    cycles = n;
    $display("txn %s: data=0x%08h err=%0b after %0d cycles", tag, res_data, res_err, n);
  endtask

  task automatic consume();
    @(negedge clk);
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    res_ready = 1'b0;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int          cyc;
    int          sent;
    int          got;
    int          last;
    logic        acc;
    logic [31:0] exp_sum [3];
    logic [31:0] op_a    [3];
    logic [31:0] op_b    [3];

    exp_sum = '{32'd3, 32'd7, 32'd11};
    op_a    = '{32'd1, 32'd3, 32'd5};
    op_b    = '{32'd2, 32'd4, 32'd6};

    reset_n   = 1'b0;
    req_valid = 1'b0;
    req_op    = ALU_NOP;
    req_a     = 32'h0;
    req_b     = 32'h0;
    req_idim  = 1'b0;
    res_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_res_valid", {31'h0, res_valid}, 32'h0);
    check("rst_req_ready", {31'h0, req_ready}, 32'h1);
    check("rst_alu_op", 32'(alu_op), 32'(ALU_NOP));
    check("rst_alu_a", alu_a, 32'h0);
    check("rst_res_data", res_data, 32'h0);
    check("rst_res_err", {31'h0, res_err}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    // 1: single-cycle AND
    mode = 0;
    send(ALU_AND, 32'hF0F0_1234, 32'h0FF0_FFFF);
    check("and_setup_op", 32'(alu_op), 32'(ALU_NOP));
    check("and_setup_a", alu_a, 32'hF0F0_1234);
    check("and_setup_b", alu_b, 32'h0FF0_FFFF);
    check("and_setup_busy", {31'h0, busy}, 32'h1);
    check("and_setup_req_ready", {31'h0, req_ready}, 32'h0);
    @(negedge clk);
    #1;
    check("and_exec_op", 32'(alu_op), 32'(ALU_AND));
    check("and_exec_res_valid", {31'h0, res_valid}, 32'h0);
    wait_result("and", cyc);
    check("and_latency", 32'(cyc), 32'd1);
    check("and_data", res_data, 32'h00F0_1234);
    check("and_err", {31'h0, res_err}, 32'h0);
    check("and_result_op", 32'(alu_op), 32'(ALU_NOP));
    consume();
    check("and_idle_busy", {31'h0, busy}, 32'h0);
    check("and_idle_res_valid", {31'h0, res_valid}, 32'h0);

    // 2: multicycle MULT, done on fourth EXEC cycle
    mode = 1;
    lat  = 4;
    send(ALU_MULT, 32'd7, 32'd6);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      #1;
      check($sformatf("mult_exec%0d_op", i), 32'(alu_op), 32'(ALU_MULT));
      check($sformatf("mult_exec%0d_a", i), alu_a, 32'd7);
      check($sformatf("mult_exec%0d_b", i), alu_b, 32'd6);
      check($sformatf("mult_exec%0d_res_valid", i), {31'h0, res_valid}, 32'h0);
    end
    wait_result("mult", cyc);
    check("mult_latency", 32'(cyc), 32'd1);
    check("mult_data", res_data, 32'd42);
    check("mult_err", {31'h0, res_err}, 32'h0);
    consume();

    // 3: barrel arithmetic right shift relies on SETUP preload
    mode = 0;
    send(ALU_BARREL, 32'h8000_0000, 32'h0000_0004);
    wait_result("barrel", cyc);
    check("barrel_data", res_data, 32'hF800_0000);
    consume();

    // 4: back-to-back PLUS with res_ready held high
    res_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = ALU_PLUS;
    req_a     = op_a[0];
    req_b     = op_b[0];
    sent = 0;
    got  = 0;
    last = 0;
    for (int c = 0; c < 40 && got < 3; c++) begin
      #1;
      if (res_valid) begin
        $display("txn b2b%0d: data=0x%08h err=%0b cycle=%0d", got, res_data, res_err, c);
        check($sformatf("b2b%0d_data", got), res_data, exp_sum[got]);
        check($sformatf("b2b%0d_op_nop", got), 32'(alu_op), 32'(ALU_NOP));
        if (got > 0) check($sformatf("b2b%0d_gap", got), 32'(c - last), 32'd3);
        last = c;
        got++;
      end
      acc = req_valid && req_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        sent++;
        if (sent < 3) begin
          req_a = op_a[sent];
          req_b = op_b[sent];
        end else begin
          req_valid = 1'b0;
        end
      end
      @(negedge clk);
    end
    check("b2b_count", 32'(got), 32'd3);
    res_ready = 1'b0;
    req_valid = 1'b0;

    // 5: watchdog abort, then a normal op
    mode = 2;
    send(ALU_PLUS, 32'd1, 32'd1);
    wait_result("timeout", cyc);
    check("timeout_cycles", 32'(cyc), 32'd51);
    check("timeout_err", {31'h0, res_err}, 32'h1);
    check("timeout_data", res_data, 32'h0);
    check("timeout_op_nop", 32'(alu_op), 32'(ALU_NOP));
    consume();
    mode = 0;
    send(ALU_PLUS, 32'd2, 32'd3);
    wait_result("post_timeout", cyc);
    check("post_timeout_data", res_data, 32'd5);
    check("post_timeout_err", {31'h0, res_err}, 32'h0);
    consume();

    // 6: backpressure, then reset in the middle of a DIV
    send(ALU_OR, 32'h1200_0034, 32'h0056_0000);
    wait_result("bp", cyc);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      check($sformatf("bp%0d_data", i), res_data, 32'h1256_0034);
      check($sformatf("bp%0d_req_ready", i), {31'h0, req_ready}, 32'h0);
      check($sformatf("bp%0d_op", i), 32'(alu_op), 32'(ALU_NOP));
    end
    check("bp_res_valid", {31'h0, res_valid}, 32'h1);
    consume();

    mode = 1;
    lat  = 30;
    send(ALU_DIV, 32'd100, 32'd7);
    repeat (5) @(negedge clk);
    #1;
    check("div_exec_op", 32'(alu_op), 32'(ALU_DIV));
    #2;
    reset_n = 1'b0;
    #1;
    check("div_rst_busy", {31'h0, busy}, 32'h0);
    check("div_rst_res_valid", {31'h0, res_valid}, 32'h0);
    check("div_rst_op", 32'(alu_op), 32'(ALU_NOP));
    check("div_rst_req_ready", {31'h0, req_ready}, 32'h1);
    $display("txn div_reset: busy=%0b res_valid=%0b alu_op=%0d", busy, res_valid, alu_op);
    @(negedge clk);
    reset_n = 1'b1;
    mode = 0;
    send(ALU_PLUS, 32'd10, 32'd20);
    wait_result("post_reset", cyc);
    check("post_reset_data", res_data, 32'd30);
    consume();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
